// File: rtl/tomasulo_pkg.sv
// tomasulo_pkg: shared CDB widths, buffer depth, tag encoding and grant type
package tomasulo_pkg;
    localparam int DATA_W = 8;
    localparam int TAG_W = 4;
    localparam int CDB_DEPTH = 2;
    localparam logic [TAG_W-1:0] TAG_NONE = '0;
    typedef enum logic {GRANT_ADD = 1'b0, GRANT_MUL = 1'b1} grant_e;
endpackage

// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: functional-unit results in, stall and broadcast bus out
interface cdb_arbiter_if #(
    parameter int DATA_W = tomasulo_pkg::DATA_W,
    parameter int TAG_W = tomasulo_pkg::TAG_W
);
    logic add_done;
    logic [TAG_W-1:0] add_tag;
    logic [DATA_W-1:0] add_result;
    logic mul_done;
    logic [TAG_W-1:0] mul_tag;
    logic [DATA_W-1:0] mul_result;
    logic add_stall;
    logic mul_stall;
    logic cdb_valid;
    logic [TAG_W-1:0] cdb_tag;
    logic [DATA_W-1:0] cdb_value;
    logic err_overflow;
    modport master (
        output add_done, add_tag, add_result, mul_done, mul_tag, mul_result,
        input add_stall, mul_stall, cdb_valid, cdb_tag, cdb_value, err_overflow
    );
    modport slave (
        input add_done, add_tag, add_result, mul_done, mul_tag, mul_result,
        output add_stall, mul_stall, cdb_valid, cdb_tag, cdb_value, err_overflow
    );
endinterface

// File: rtl/cdb_fifo.sv
// cdb_fifo: per-source result buffer; an incoming entry bypasses an empty buffer when granted
module cdb_fifo #(
    parameter int W = 12,
    parameter int DEPTH = 2
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         wr,
    input  logic [W-1:0] wr_data,
    input  logic         rd,
    output logic         avail,
    output logic [W-1:0] head,
    output logic         full,
    output logic         drop
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    logic [W-1:0] mem [DEPTH];
    logic [PW-1:0] wp, rp;
    logic [CW-1:0] cnt;
    logic empty, pop, push;
    assign empty = cnt == '0;
    assign full = cnt == CW'(DEPTH);
    assign avail = !empty || wr;
    assign head = empty ? wr_data : mem[rp];
    assign pop = rd && !empty;
    assign push = wr && !empty ? (!full || pop) : wr && !rd;
    assign drop = wr && full && !pop;
    // pointers wrap modulo DEPTH; count moves by push minus pop
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wp <= '0;
            rp <= '0;
            cnt <= '0;
        end else begin
            if (push) wp <= wp == PW'(DEPTH - 1) ? '0 : wp + 1'b1;
            if (pop) rp <= rp == PW'(DEPTH - 1) ? '0 : rp + 1'b1;
            cnt <= cnt + CW'(push) - CW'(pop);
        end
    end
    // storage needs no reset; count alone decides which entries are live
    always_ff @(posedge clock) begin
        if (push) mem[wp] <= wr_data;
    end
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin merge of add/sub and mul/div results onto one registered CDB
module cdb_arbiter #(
    parameter int DATA_W = tomasulo_pkg::DATA_W,
    parameter int TAG_W = tomasulo_pkg::TAG_W,
    parameter int DEPTH = tomasulo_pkg::CDB_DEPTH
) (
    input logic         clock,
    input logic         reset_n,
    cdb_arbiter_if.slave bus
);
    import tomasulo_pkg::*;
    localparam int EW = TAG_W + DATA_W;
    logic [EW-1:0] add_head, mul_head;
    logic add_avail, mul_avail, add_drop, mul_drop, add_rd, mul_rd;
    grant_e last_grant;
    cdb_fifo #(.W(EW), .DEPTH(DEPTH)) u_add_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .wr      (bus.add_done && bus.add_tag != TAG_W'(TAG_NONE)),
        .wr_data ({bus.add_tag, bus.add_result}),
        .rd      (add_rd),
        .avail   (add_avail),
        .head    (add_head),
        .full    (bus.add_stall),
        .drop    (add_drop)
    );
    cdb_fifo #(.W(EW), .DEPTH(DEPTH)) u_mul_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .wr      (bus.mul_done && bus.mul_tag != TAG_W'(TAG_NONE)),
        .wr_data ({bus.mul_tag, bus.mul_result}),
        .rd      (mul_rd),
        .avail   (mul_avail),
        .head    (mul_head),
        .full    (bus.mul_stall),
        .drop    (mul_drop)
    );
    // grant the lone pending source, or the one not granted last when both pend
    always_comb begin
        add_rd = add_avail && (!mul_avail || last_grant == GRANT_MUL);
        mul_rd = mul_avail && !add_rd;
    end
    // broadcast register, round-robin pointer and sticky overflow flag
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bus.cdb_valid <= 1'b0;
            bus.cdb_tag <= '0;
            bus.cdb_value <= '0;
            bus.err_overflow <= 1'b0;
            last_grant <= GRANT_MUL;
        end else begin
            bus.cdb_valid <= add_rd || mul_rd;
            if (add_rd || mul_rd) begin
                {bus.cdb_tag, bus.cdb_value} <= add_rd ? add_head : mul_head;
                last_grant <= add_rd ? GRANT_ADD : GRANT_MUL;
            end
            if (add_drop || mul_drop) bus.err_overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed checks of latency, round-robin, stalls, overflow and reset
module tb_cdb_arbiter;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int total = 0;
    int bad = 0;
    cdb_arbiter_if bus ();
    cdb_arbiter dut (.clock(clock), .reset_n(reset_n), .bus(bus));
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string n, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", n, obs, exp);
        end
    endtask

    task automatic drive(input logic ad, input logic [3:0] at, input logic [7:0] ar,
                         input logic md, input logic [3:0] mt, input logic [7:0] mr);
        bus.add_done = ad;
        bus.add_tag = at;
        bus.add_result = ar;
        bus.mul_done = md;
        bus.mul_tag = mt;
        bus.mul_result = mr;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0);
    endtask

    task automatic cdb(input string n, input logic v, input logic [3:0] t, input logic [7:0] d);
        check({n, "_valid"}, 32'(bus.cdb_valid), 32'(v));
        check({n, "_tag"}, 32'(bus.cdb_tag), 32'(t));
        check({n, "_value"}, 32'(bus.cdb_value), 32'(d));
    endtask

    task automatic do_reset();
        idle();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        idle();
        do_reset();
        cdb("rst", 0, 0, 8'h00);
        check("rst_add_stall", 32'(bus.add_stall), 0);
        check("rst_mul_stall", 32'(bus.mul_stall), 0);
        check("rst_err", 32'(bus.err_overflow), 0);

        drive(1, 3, 8'h06, 0, 0, 0);
        tick();
        cdb("lat1", 1, 3, 8'h06);
        idle();
        tick();
        cdb("lat2", 0, 3, 8'h06);

        do_reset();
        drive(1, 1, 8'h05, 1, 4, 8'h0C);
        tick();
        cdb("same1", 1, 1, 8'h05);
        idle();
        tick();
        cdb("same2", 1, 4, 8'h0C);
        tick();
        cdb("same3", 0, 4, 8'h0C);

        do_reset();
        drive(1, 7, 8'h77, 1, 4, 8'h44);
        tick();
        cdb("rr0", 1, 7, 8'h77);
        drive(1, 1, 8'h11, 1, 5, 8'h55);
        tick();
        cdb("rr1", 1, 4, 8'h44);
        drive(1, 2, 8'h22, 1, 6, 8'h66);
        tick();
        cdb("rr2", 1, 1, 8'h11);
        check("rr2_mul_stall", 32'(bus.mul_stall), 1);
        drive(1, 3, 8'h33, 0, 0, 0);
        tick();
        cdb("rr3", 1, 5, 8'h55);
        check("rr3_add_stall", 32'(bus.add_stall), 1);
        check("rr3_mul_stall", 32'(bus.mul_stall), 0);
        idle();
        tick();
        cdb("rr4", 1, 2, 8'h22);
        check("rr4_add_stall", 32'(bus.add_stall), 0);
        tick();
        cdb("rr5", 1, 6, 8'h66);
        tick();
        cdb("rr6", 1, 3, 8'h33);
        tick();
        cdb("rr7", 0, 3, 8'h33);

        do_reset();
        drive(1, 1, 8'h11, 1, 9, 8'h99);
        tick();
        cdb("ov0", 1, 1, 8'h11);
        drive(1, 2, 8'h22, 1, 10, 8'hAA);
        tick();
        cdb("ov1", 1, 9, 8'h99);
        drive(1, 3, 8'h33, 1, 4, 8'h44);
        tick();
        cdb("ov2", 1, 2, 8'h22);
        check("ov2_mul_stall", 32'(bus.mul_stall), 1);
        drive(0, 0, 0, 1, 5, 8'h55);
        tick();
        cdb("ov3", 1, 10, 8'hAA);
        check("ov3_mul_stall", 32'(bus.mul_stall), 1);
        check("ov3_err", 32'(bus.err_overflow), 0);
        drive(0, 0, 0, 1, 6, 8'h66);
        tick();
        cdb("ov4", 1, 3, 8'h33);
        check("ov4_err", 32'(bus.err_overflow), 1);
        check("ov4_mul_stall", 32'(bus.mul_stall), 1);
        idle();
        tick();
        cdb("ov5", 1, 4, 8'h44);
        check("ov5_mul_stall", 32'(bus.mul_stall), 0);
        tick();
        cdb("ov6", 1, 5, 8'h55);
        tick();
        cdb("ov7", 0, 5, 8'h55);
        tick();
        tick();
        cdb("ov9", 0, 5, 8'h55);
        check("ov9_err", 32'(bus.err_overflow), 1);
        do_reset();
        check("ov_rst_err", 32'(bus.err_overflow), 0);

        drive(1, 0, 8'hEE, 0, 0, 0);
        tick();
        cdb("none1", 0, 0, 8'h00);
        check("none_err", 32'(bus.err_overflow), 0);
        check("none_add_stall", 32'(bus.add_stall), 0);
        idle();
        tick();
        cdb("none2", 0, 0, 8'h00);

        do_reset();
        drive(1, 1, 8'h11, 1, 9, 8'h99);
        tick();
        drive(1, 2, 8'h22, 1, 10, 8'hAA);
        tick();
        drive(1, 3, 8'h33, 1, 4, 8'h44);
        tick();
        check("pre_valid", 32'(bus.cdb_valid), 1);
        check("pre_mul_stall", 32'(bus.mul_stall), 1);
        idle();
        #3;
        reset_n = 1'b0;
        #1;
        cdb("async", 0, 0, 8'h00);
        check("async_add_stall", 32'(bus.add_stall), 0);
        check("async_mul_stall", 32'(bus.mul_stall), 0);
        check("async_err", 32'(bus.err_overflow), 0);
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("post_rst_valid", 32'(bus.cdb_valid), 0);
        end
        drive(1, 7, 8'h77, 0, 0, 0);
        tick();
        cdb("post1", 1, 7, 8'h77);
        idle();
        tick();
        cdb("post2", 0, 7, 8'h77);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
